// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises bitstream words LSB-first onto ccff_head,
// gates chain shifting with shift_en and packs the displaced ccff_tail bits into
// readback words.
module ccff_chain_loader #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CHAIN_LEN = 74,
  localparam int unsigned CNT_W    = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  // Word shifter fill count must reach DATA_W; readback index only reaches DATA_W-1.
  localparam int unsigned WCNT_W = $clog2(DATA_W + 1);
  localparam int unsigned RBI_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   wsh_q, wsh_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]    req_left_q, req_left_d;
  logic [CNT_W-1:0]    shift_left_q, shift_left_d;
  logic [DATA_W-1:0]   rb_sh_q, rb_sh_d;
  logic [RBI_W-1:0]    rb_idx_q, rb_idx_d;
  logic [DATA_W-1:0]   rb_data_q, rb_data_d;
  logic                rb_valid_q, rb_valid_d;

  logic                shifting;
  logic                handshake;
  logic                last_shift;
  logic [WCNT_W-1:0]   take;
  logic [DATA_W-1:0]   rb_word;

  // A shift happens whenever the word shifter still holds a bit.
  assign shifting   = (state_q == StLoad) && (wcnt_q != '0);
  // Ready when empty or about to empty, so a held cfg_valid streams without bubbles.
  assign cfg_ready  = (state_q == StLoad) && (req_left_q != '0) && (wcnt_q <= WCNT_W'(1));
  assign handshake  = cfg_ready && cfg_valid;
  assign last_shift = shifting && (shift_left_q == CNT_W'(1));
  // Partial last word: only the bits still needed by the chain are kept.
  assign take       = (32'(req_left_q) >= DATA_W) ? WCNT_W'(DATA_W) : WCNT_W'(req_left_q);

  assign shift_en  = shifting;
  assign ccff_head = shifting & wsh_q[0];
  assign busy      = (state_q == StLoad);
  assign done      = (state_q == StDone);
  assign rb_data   = rb_data_q;
  assign rb_valid  = rb_valid_q;

  // Readback word with the tail bit sampled this cycle merged in at its slot.
  always_comb begin
    rb_word           = rb_sh_q;
    rb_word[rb_idx_q] = ccff_tail;
  end

  // Next-state logic for the FSM, counters, word shifter and readback packer.
  always_comb begin
    state_d      = state_q;
    wsh_d        = wsh_q;
    wcnt_d       = wcnt_q;
    req_left_d   = req_left_q;
    shift_left_d = shift_left_q;
    rb_sh_d      = rb_sh_q;
    rb_idx_d     = rb_idx_q;
    rb_data_d    = rb_data_q;
    rb_valid_d   = 1'b0;

    if (abort) begin
      // Chain is left as-is; any partially packed readback word is dropped.
      state_d      = StIdle;
      wsh_d        = '0;
      wcnt_d       = '0;
      req_left_d   = '0;
      shift_left_d = '0;
      rb_sh_d      = '0;
      rb_idx_d     = '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d      = StLoad;
            wsh_d        = '0;
            wcnt_d       = '0;
            req_left_d   = CNT_W'(CHAIN_LEN);
            shift_left_d = CNT_W'(CHAIN_LEN);
            rb_sh_d      = '0;
            rb_idx_d     = '0;
          end
        end
        StLoad: begin
          if (shifting) begin
            wsh_d        = wsh_q >> 1;
            wcnt_d       = wcnt_q - WCNT_W'(1);
            shift_left_d = shift_left_q - CNT_W'(1);
            if (last_shift || (rb_idx_q == RBI_W'(DATA_W - 1))) begin
              // Full word, or final partial word with zero upper bits.
              rb_data_d  = rb_word;
              rb_valid_d = 1'b1;
              rb_sh_d    = '0;
              rb_idx_d   = '0;
            end else begin
              rb_sh_d  = rb_word;
              rb_idx_d = rb_idx_q + RBI_W'(1);
            end
            if (last_shift) begin
              state_d = StDone;
            end
          end
          // A word accepted on the shifter's last bit replaces it for the next cycle.
          if (handshake) begin
            wsh_d      = cfg_data;
            wcnt_d     = take;
            req_left_d = req_left_q - CNT_W'(take);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state_q      <= StIdle;
      wsh_q        <= '0;
      wcnt_q       <= '0;
      req_left_q   <= '0;
      shift_left_q <= '0;
      rb_sh_q      <= '0;
      rb_idx_q     <= '0;
      rb_data_q    <= '0;
      rb_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wsh_q        <= wsh_d;
      wcnt_q       <= wcnt_d;
      req_left_q   <= req_left_d;
      shift_left_q <= shift_left_d;
      rb_sh_q      <= rb_sh_d;
      rb_idx_q     <= rb_idx_d;
      rb_data_q    <= rb_data_d;
      rb_valid_q   <= rb_valid_d;
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 10-bit chain fixture driven by shift_en/ccff_head,
// loads with random words, stalls and control pulses, checked against bit-list
// expectations built from the words and the chain snapshot.
module tb_ccff_chain_loader;

  localparam int DATA_W    = 8;
  localparam int CHAIN_LEN = 10;
  localparam int NRB       = (CHAIN_LEN + DATA_W - 1) / DATA_W;

  logic              prog_clk = 1'b0;
  logic              pReset   = 1'b0;
  logic              start    = 1'b0;
  logic              abort    = 1'b0;
  logic [DATA_W-1:0] cfg_data = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic              ccff_head;
  logic              ccff_tail;
  logic              shift_en;
  logic [DATA_W-1:0] rb_data;
  logic              rb_valid;
  logic              busy;
  logic              done;

  // Chain fixture: head enters bit 0, tail leaves from the top bit.
  logic [CHAIN_LEN-1:0] chain = 10'h3A5;
  assign ccff_tail = chain[CHAIN_LEN-1];

  always #5 prog_clk = ~prog_clk;

  // The chain shifts on the edges where the loader enables it.
  always @(posedge prog_clk) begin
    if (shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
  end

  ccff_chain_loader #(
    .DATA_W   (DATA_W),
    .CHAIN_LEN(CHAIN_LEN)
  ) dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .start    (start),
    .abort    (abort),
    .cfg_data (cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .ccff_head(ccff_head),
    .ccff_tail(ccff_tail),
    .shift_en (shift_en),
    .rb_data  (rb_data),
    .rb_valid (rb_valid),
    .busy     (busy),
    .done     (done)
  );

  int checks   = 0;
  int failures = 0;

  // Observations collected by run_load.
  logic [CHAIN_LEN-1:0] old_chain;
  logic [CHAIN_LEN-1:0] obs_vec;
  logic [DATA_W-1:0]    obs_rb[$];
  int nshift, ngap, hs0_cyc, first_shift_cyc, last_shift_cyc, done_cyc, rb0_cyc;
  bit timed_out, ready_late, done_busy, done_shift;

  // Starts a load and streams two words; optional stall before word 2, an
  // ignored start pulse, and an early stop after stop_at shifts.
  task automatic run_load(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                          input int stall_len, input int start_at, input int stop_at);
    int  wi;
    int  stall_rem;
    bit  stalled;
    bit  sp_done;
    wi = 0; stall_rem = 0; stalled = 0; sp_done = 0;
    old_chain = chain; obs_vec = '0; obs_rb.delete();
    nshift = 0; ngap = 0; hs0_cyc = -1; first_shift_cyc = -1; last_shift_cyc = -1;
    done_cyc = -1; rb0_cyc = -1; timed_out = 1; ready_late = 0; done_busy = 0;
    done_shift = 0;
    @(negedge prog_clk);
    start = 1'b1; cfg_valid = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge prog_clk);
      start = (start_at >= 0) && !sp_done && (nshift == start_at);
      if (start) sp_done = 1;
      if (!stalled && stall_len > 0 && wi == 1 && cfg_ready) begin
        stalled = 1; stall_rem = stall_len;
      end
      if (stall_rem > 0) begin
        cfg_valid = 1'b0; stall_rem--;
      end else begin
        cfg_valid = (wi < 2);
        cfg_data  = (wi == 0) ? w0 : w1;
      end
      if (shift_en) begin
        if (nshift < CHAIN_LEN) obs_vec[nshift] = ccff_head;
        if (nshift == 0) first_shift_cyc = cyc;
        nshift++;
        last_shift_cyc = cyc;
      end else if (nshift > 0 && nshift < CHAIN_LEN) begin
        ngap++;
      end
      if (rb_valid) begin
        if (obs_rb.size() == 0) rb0_cyc = cyc;
        obs_rb.push_back(rb_data);
      end
      if (cfg_ready && wi >= 2) ready_late = 1;
      if (cfg_ready && cfg_valid) begin
        if (wi == 0) hs0_cyc = cyc;
        wi++;
      end
      if (done) begin
        done_cyc = cyc; done_busy = busy; done_shift = shift_en; timed_out = 0;
        start = 1'b0; cfg_valid = 1'b0;
        break;
      end
      if (stop_at > 0 && nshift == stop_at) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit seen;
    seen = 0;
    pReset = 1'b0; start = 1'b1; abort = 1'b0; cfg_valid = 1'b0;
    repeat (2) @(negedge prog_clk);
    checks++;
    if ({busy, done, shift_en, ccff_head, cfg_ready, rb_valid} !== 6'b0 || rb_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b sh=%b head=%b rdy=%b rbv=%b rb=%h want all 0",
               busy, done, shift_en, ccff_head, cfg_ready, rb_valid, rb_data);
    end
    pReset = 1'b1; start = 1'b0;
    repeat (4) begin
      @(negedge prog_clk);
      if (busy !== 1'b0 || shift_en !== 1'b0 || cfg_ready !== 1'b0 || done !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_no_load: got activity=1 want 0 without a fresh start");
    end
  endtask

  task automatic test_stream(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                             input int stall_len, input int start_at, input string name);
    logic [CHAIN_LEN-1:0] exp_vec, exp_chain, tail_seq;
    logic [DATA_W-1:0]    exp_rb[NRB];
    run_load(w0, w1, stall_len, start_at, 0);
    // Expected bitstream: words LSB-first, truncated to the chain length.
    for (int i = 0; i < CHAIN_LEN; i++) begin
      exp_vec[i] = (i < DATA_W) ? w0[i] : w1[i-DATA_W];
    end
    for (int i = 0; i < CHAIN_LEN; i++) begin
      exp_chain[CHAIN_LEN-1-i] = exp_vec[i];
      tail_seq[i]              = old_chain[CHAIN_LEN-1-i];
    end
    for (int k = 0; k < NRB; k++) begin
      exp_rb[k] = '0;
      for (int j = 0; j < DATA_W; j++) begin
        if (k * DATA_W + j < CHAIN_LEN) exp_rb[k][j] = tail_seq[k*DATA_W+j];
      end
    end

    checks++;
    if (timed_out) begin
      failures++; $display("FAIL %s done_reached: got timeout want done", name);
    end
    checks++;
    if (nshift !== CHAIN_LEN) begin
      failures++; $display("FAIL %s shift_count: got %0d want %0d", name, nshift, CHAIN_LEN);
    end
    checks++;
    if (obs_vec !== exp_vec) begin
      failures++; $display("FAIL %s head_bits: got %b want %b", name, obs_vec, exp_vec);
    end
    checks++;
    if (first_shift_cyc !== hs0_cyc + 1) begin
      failures++;
      $display("FAIL %s first_latency: got cyc %0d want %0d", name, first_shift_cyc, hs0_cyc + 1);
    end
    checks++;
    if (ngap !== stall_len) begin
      failures++; $display("FAIL %s stall_gaps: got %0d want %0d", name, ngap, stall_len);
    end
    checks++;
    if (done_cyc !== last_shift_cyc + 1 || done_busy !== 1'b0 || done_shift !== 1'b0) begin
      failures++;
      $display("FAIL %s done_timing: got cyc %0d busy=%b sh=%b want cyc %0d busy=0 sh=0",
               name, done_cyc, done_busy, done_shift, last_shift_cyc + 1);
    end
    checks++;
    if (ready_late !== 1'b0) begin
      failures++; $display("FAIL %s ready_after_last: got 1 want 0", name);
    end
    checks++;
    if (obs_rb.size() !== NRB) begin
      failures++; $display("FAIL %s rb_count: got %0d want %0d", name, obs_rb.size(), NRB);
    end
    for (int k = 0; k < NRB; k++) begin
      if (k < obs_rb.size()) begin
        checks++;
        if (obs_rb[k] !== exp_rb[k]) begin
          failures++;
          $display("FAIL %s rb_word%0d: got %h want %h", name, k, obs_rb[k], exp_rb[k]);
        end
      end
    end
    checks++;
    if (rb0_cyc !== first_shift_cyc + DATA_W) begin
      failures++;
      $display("FAIL %s rb_first_timing: got cyc %0d want %0d", name, rb0_cyc,
               first_shift_cyc + DATA_W);
    end
    checks++;
    if (chain !== exp_chain) begin
      failures++; $display("FAIL %s chain_contents: got %h want %h", name, chain, exp_chain);
    end
  endtask

  task automatic test_abort();
    bit rb_seen;
    rb_seen = 0;
    run_load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, -1, 4);
    checks++;
    if (nshift !== 4) begin
      failures++; $display("FAIL abort_pre_shifts: got %0d want 4", nshift);
    end
    @(negedge prog_clk);
    abort = 1'b1; cfg_valid = 1'b0;
    @(negedge prog_clk);
    abort = 1'b0;
    checks++;
    if ({busy, done, shift_en, ccff_head, cfg_ready} !== 5'b0) begin
      failures++;
      $display("FAIL abort_idle: got busy=%b done=%b sh=%b head=%b rdy=%b want all 0",
               busy, done, shift_en, ccff_head, cfg_ready);
    end
    repeat (3) begin
      if (rb_valid !== 1'b0 || shift_en !== 1'b0) rb_seen = 1;
      @(negedge prog_clk);
    end
    checks++;
    if (rb_seen) begin
      failures++; $display("FAIL abort_quiet: got rb_valid/shift_en activity want none");
    end
    test_stream(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, -1, "reload");
  endtask

  task automatic test_start_abort();
    bit active;
    active = 0;
    test_stream(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 3, "busy_start");
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL start_abort_pre: got done=%b want 1", done);
    end
    start = 1'b1; abort = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || shift_en !== 1'b0) begin
      failures++;
      $display("FAIL start_abort_idle: got done=%b busy=%b sh=%b want 0 0 0", done, busy, shift_en);
    end
    repeat (3) begin
      @(negedge prog_clk);
      if (busy !== 1'b0 || cfg_ready !== 1'b0) active = 1;
    end
    checks++;
    if (active) begin
      failures++; $display("FAIL start_abort_stays_idle: got busy activity want none");
    end
  endtask

  task automatic test_reset_midload();
    test_stream(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, -1, "pre_reset");
    pReset = 1'b0;
    @(negedge prog_clk);
    pReset = 1'b1;
    checks++;
    if (done !== 1'b0 || rb_data !== 8'h00) begin
      failures++; $display("FAIL reset_clears_done: got done=%b rb=%h want 0 00", done, rb_data);
    end
    run_load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, -1, 3);
    pReset = 1'b0; cfg_valid = 1'b0;
    @(negedge prog_clk);
    pReset = 1'b1;
    checks++;
    if ({busy, done, shift_en, cfg_ready, rb_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_midload: got busy=%b done=%b sh=%b rdy=%b rbv=%b want all 0",
               busy, done, shift_en, cfg_ready, rb_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 5; n++) begin
      test_stream(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 9)) - 1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_stream(8'hC3, 8'h02, 0, -1, "stream");
    test_stream(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3, -1, "stall");
    test_abort();
    test_start_abort();
    test_reset_midload();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
